// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: steps one active-low column at a time, assembles a
// 16-key frame every four steps and debounces single-key presses across frames.
module keypad_scanner #(
  parameter int DIV_RATE     = 9,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_down_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_DOWN,
    S_RELEASE_CHK
  } state_t;

  localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

  logic [3:0]          r_sync1, r_sync2;
  logic [DIV_RATE-1:0] r_presc;
  logic [1:0]          r_col;
  logic [3:0]          r_col_o;
  logic [15:0]         r_frame;
  logic                r_frame_done;
  state_t              r_state;
  logic [3:0]          r_cnt, r_cand, r_code;
  logic                r_valid, r_down;

  logic                w_tick;
  logic [1:0]          w_next_col;
  logic [4:0]          w_ones;
  logic [3:0]          w_idx;
  logic                w_empty, w_single, w_match;
  logic [3:0]          w_cnt_inc;

  assign w_tick     = &r_presc;
  assign w_next_col = r_col + 2'd1;
  assign w_cnt_inc  = r_cnt + 4'd1;

  // Rows are sampled at the end of each column's dwell, after the synchronizer settles.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_sync1      <= 4'hF;
      r_sync2      <= 4'hF;
      r_presc      <= '0;
      r_col        <= '0;
      r_col_o      <= 4'b1110;
      r_frame      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync1      <= row_i;
      r_sync2      <= r_sync1;
      r_presc      <= r_presc + {{(DIV_RATE-1){1'b0}}, 1'b1};
      r_frame_done <= w_tick && (r_col == 2'd3);
      if (w_tick) begin
        r_frame[{r_col, 2'b00} +: 4] <= ~r_sync2;
        r_col                        <= w_next_col;
        r_col_o                      <= ~(4'b0001 << w_next_col);
      end
    end
  end

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (r_frame[i]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(i);
      end
    end
  end

  assign w_empty  = (w_ones == 5'd0);
  assign w_single = (w_ones == 5'd1);
  assign w_match  = w_single && (w_idx == r_cand);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_frame_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_state <= S_PRESS_CHK;
              r_cand  <= w_idx;
              r_cnt   <= 4'd1;
            end
          end
          S_PRESS_CHK: begin
            if (w_match) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DB) begin
                r_state <= S_DOWN;
                r_code  <= r_cand;
                r_valid <= 1'b1;
                r_down  <= 1'b1;
              end
            end else if (w_single) begin
              r_cand <= w_idx;
              r_cnt  <= 4'd1;
            end else if (w_empty) begin
              r_state <= S_IDLE;
            end
          end
          S_DOWN: begin
            if (w_empty || (w_single && !w_match)) begin
              r_state <= S_RELEASE_CHK;
              r_cnt   <= 4'd1;
            end
          end
          S_RELEASE_CHK: begin
            if (w_empty) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DB) begin
                r_state <= S_IDLE;
                r_down  <= 1'b0;
              end
            end else if (w_match) begin
              r_state <= S_DOWN;
              r_cnt   <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign col_o       = r_col_o;
  assign key_code_o  = r_code;
  assign key_valid_o = r_valid;
  assign key_down_o  = r_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model, pulse monitor and
// immediate-assertion checks over a linear stimulus sequence.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  row, col, code;
  logic        valid, down;
  logic [15:0] keys = '0;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          n_pulse = 0;
  int          n_fall = 0;
  int          last_pulse_cyc = 0;
  logic [3:0]  pulse_code = '0;
  logic        prev_down = 1'b0;

  int np, nf, p0, rel;

  keypad_scanner #(.DIV_RATE(2), .DEBOUNCE_CNT(3)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .row_i      (row),
    .col_o      (col),
    .key_code_o (code),
    .key_valid_o(valid),
    .key_down_o (down)
  );

  always #5 clk = ~clk;

  // A pressed key (c,r) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      n_pulse++;
      last_pulse_cyc = cyc;
      pulse_code = code;
    end
    if (prev_down && !down) n_fall++;
    prev_down = down;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after col_o wraps from column 3 back to column 0.
  task automatic wait_frame_start();
    logic [3:0] prev;
    prev = col;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && col == 4'b1110) return;
      prev = col;
    end
    chk("frame_align_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // 1: reset state and column stepping
    cycles(3);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", code, 4'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_down", down, 1'b0);
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      if (col != 4'b1110) break;
    end
    chk("col1", col, 4'b1101);
    cycles(4);
    chk("col2", col, 4'b1011);
    cycles(4);
    chk("col3", col, 4'b0111);
    cycles(4);
    chk("col0_wrap", col, 4'b1110);
    cycles(200);
    chk("idle_no_pulse", n_pulse, 0);
    chk("idle_down", down, 1'b0);

    // 2: key 9 press
    wait_frame_start();
    keys[9] = 1'b1;
    p0 = cyc;
    np = n_pulse;
    cycles(100);
    chk("k9_one_pulse", n_pulse, np + 1);
    chk("k9_pulse_code", pulse_code, 4'h9);
    chk_rng("k9_latency", last_pulse_cyc - p0, 40, 60);
    chk("k9_down", down, 1'b1);
    chk("k9_code", code, 4'h9);

    // 3: key 9 release
    keys = '0;
    np = n_pulse;
    cycles(20);
    chk("k9_down_held_early", down, 1'b1);
    cycles(100);
    chk("k9_released", down, 1'b0);
    chk("k9_rel_no_pulse", n_pulse, np);
    chk("k9_code_kept", code, 4'h9);
    chk("k9_one_fall", n_fall, 1);

    // 4: bounce from idle, then bounce while down
    nf = n_fall;
    np = n_pulse;
    for (int i = 0; i < 6; i++) begin
      wait_frame_start();
      keys[5] = 1'b1;
      wait_frame_start();
      keys[5] = 1'b0;
    end
    wait_frame_start();
    wait_frame_start();
    chk("bounce_no_pulse", n_pulse, np);
    chk("bounce_no_fall", n_fall, nf);
    chk("bounce_down", down, 1'b0);
    keys[5] = 1'b1;
    cycles(100);
    chk("k5_pulse", n_pulse, np + 1);
    chk("k5_code", code, 4'h5);
    chk("k5_down", down, 1'b1);
    wait_frame_start();
    keys[5] = 1'b0;
    wait_frame_start();
    keys[5] = 1'b1;
    cycles(80);
    chk("k5_rebounce_no_fall", n_fall, nf);
    chk("k5_rebounce_no_pulse", n_pulse, np + 1);
    chk("k5_rebounce_down", down, 1'b1);
    keys = '0;
    cycles(100);
    chk("k5_released", down, 1'b0);

    // 5: ghosting
    np = n_pulse;
    keys = 16'h8001;
    cycles(120);
    chk("ghost_no_pulse", n_pulse, np);
    chk("ghost_down", down, 1'b0);
    keys = '0;
    cycles(40);
    keys = 16'h0008;
    cycles(100);
    chk("k3_pulse", n_pulse, np + 1);
    chk("k3_code", code, 4'h3);
    chk("k3_down", down, 1'b1);
    nf = n_fall;
    keys = 16'h0088;
    cycles(100);
    chk("k3k7_no_pulse", n_pulse, np + 1);
    chk("k3k7_down", down, 1'b1);
    chk("k3k7_code", code, 4'h3);
    chk("k3k7_no_fall", n_fall, nf);
    keys = '0;
    cycles(100);
    chk("k3_released", down, 1'b0);

    // 6: reset during press check
    np = n_pulse;
    wait_frame_start();
    keys[10] = 1'b1;
    cycles(40);
    chk("pre_reset_no_pulse", n_pulse, np);
    rstn = 1'b0;
    cycles(3);
    chk("mid_rst_code", code, 4'h0);
    chk("mid_rst_down", down, 1'b0);
    chk("mid_rst_col", col, 4'b1110);
    rstn = 1'b1;
    rel = cyc;
    cycles(40);
    chk("post_rst_no_early_pulse", n_pulse, np);
    cycles(40);
    chk("post_rst_pulse", n_pulse, np + 1);
    chk("post_rst_code", code, 4'hA);
    chk_rng("post_rst_latency", last_pulse_cyc - rel, 44, 56);
    chk("post_rst_down", down, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
